prco_pipe_ctrl: RTL
===================

Name: prco_pipe_ctrl

Overview:
Multi-cycle sequencer for the PRCO core. It drives the stage enables for fetch, decode, ALU, RAM and register writeback, and consumes the decoder's dependency flags (ce, fetch, reg_we, req_ram, req_ram_we, new_uart1_data, halt). It sits between the fetch unit, the decoder, the ALU, the RAM port and the UART transmitter, and it owns PC advance/load strobes and the halted state.

Parameters:
RAM_TIMEOUT, 16, max cycles MEM waits for i_ram_ack before bus error (>=1)
CNT_W, 16, width of the retired-instruction counter

Ports:
i_clk  in  1  clock; all logic on rising edge
i_reset  in  1  asynchronous active-high reset
i_en  in  1  run enable; sampled only on entry to FETCH
i_fetch_valid  in  1  instruction register loaded
i_dec_ce  in  1  decoder valid-op pulse
i_dec_fetch  in  1  decoder NOP/refetch pulse
i_dec_reg_we  in  1  decoded op writes a register
i_dec_req_ram  in  1  decoded op uses RAM
i_dec_req_ram_we  in  1  decoded RAM op is a store
i_dec_uart  in  1  decoded op is WRITE to UART1
i_dec_halt  in  1  decoder halt request
i_jmp_taken  in  1  branch resolved taken (sampled in EXEC)
i_ram_ack  in  1  RAM access complete
i_uart_busy  in  1  UART1 transmitter busy
q_fetch_ce  out  1  fetch request pulse
q_dec_ce  out  1  decoder i_ce pulse
q_alu_ce  out  1  ALU enable pulse
q_mem_ce  out  1  RAM request, held until ack
q_mem_we  out  1  RAM write qualifier, valid with q_mem_ce
q_wb_ce  out  1  register-file write strobe
q_uart_we  out  1  UART1 load pulse
q_pc_inc  out  1  PC+1 pulse
q_pc_load  out  1  PC load-from-branch pulse
q_halted  out  1  core halted (sticky)
q_bus_err  out  1  sticky RAM timeout flag
q_state  out  3  current state encoding
q_retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, any state, mid-access included): state IDLE; all outputs 0; q_retired 0; latched flags cleared.
- Encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. 7 is unreachable; if entered, go to HALT.
- IDLE: if i_en=1, go to FETCH.
- FETCH entry: if i_en=0, go to IDLE with no pulse. Otherwise pulse q_fetch_ce for 1 cycle, then wait for i_fetch_valid, then go to DECODE.
- DECODE: pulse q_dec_ce in the first cycle, then wait for a decoder response.
  - i_dec_halt=1 takes priority: go to HALT.
  - i_dec_fetch=1 (NOP): pulse q_pc_inc, increment q_retired, go to FETCH.
  - i_dec_ce=1: latch reg_we, req_ram, req_ram_we, uart; go to EXEC.
- EXEC: pulse q_alu_ce in the first cycle.
  - If the latched uart flag is set: hold while i_uart_busy=1. In the first cycle with busy=0, pulse q_uart_we.
  - Then route: req_ram goes to MEM; else reg_we goes to WB; else retire and go to FETCH.
- Retire action, taken in the cycle the state moves to FETCH: i_jmp_taken (sampled in EXEC, latched) selects q_pc_load, otherwise q_pc_inc. Exactly one of the two pulses, never both. q_retired increments by 1 and wraps to 0 at all-ones.
- MEM:
  - q_mem_ce=1 and q_mem_we=latched req_ram_we, both held steady until i_ram_ack.
  - Ack in the same cycle as entry is accepted.
  - On ack, drop q_mem_ce next cycle; go to WB if reg_we (load), else retire to FETCH.
  - Timeout counter starts at 0 on entry and increments each cycle without ack. Once it has counted RAM_TIMEOUT cycles, set q_bus_err, drop q_mem_ce and go to HALT.
- WB: pulse q_wb_ce for 1 cycle, retire, go to FETCH.
- HALT: q_halted=1. All strobes stay 0 and all inputs are ignored; only reset exits.
- Minimum latency per ALU op with zero-wait handshakes: FETCH(2)+DECODE(2)+EXEC(1)+WB(1) = 6 cycles.
- Decoder pulses outside DECODE are ignored.

Optional Feature:
PRCO_SINGLE_STEP_EN: adds input i_step (1 bit). When the macro is defined, FETCH entry additionally requires an i_step pulse; without one the block waits in IDLE (q_state=0), so exactly one instruction runs per pulse. i_step while busy is dropped, not queued. When the macro is undefined, the port is absent and behaviour is exactly as above.

Test Plan:
- ALU op, all acks same-cycle, i_jmp_taken=0 -> fetch/dec/alu/wb pulses in order; q_pc_inc at cycle 6; q_retired 0->1.
- Load with i_ram_ack after 3 cycles -> q_mem_ce high exactly 3 cycles with q_mem_we=0, then q_wb_ce, then q_pc_inc.
- Store with RAM_TIMEOUT=4 and ack never given -> q_mem_ce high 4 cycles with q_mem_we=1; then q_bus_err=1, q_halted=1, q_state=6; no q_pc_inc.
- WRITE with i_uart_busy high 5 cycles -> q_uart_we pulses once, in the first non-busy cycle; no q_wb_ce; then q_pc_inc.
- Branch in EXEC with i_jmp_taken=1 -> single q_pc_load pulse and no q_pc_inc; i_dec_halt in DECODE -> HALT, strobes 0, persists 20 cycles.
- Assert i_reset during MEM -> q_mem_ce drops asynchronously, q_state=0, q_retired=0; with i_en=0 after reset, block stays in IDLE.

Source files
------------

// File: rtl/prco_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : prco_pipe_ctrl
//  Description : Multi-cycle sequencer for the PRCO core. Steps each
//                instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
//                stage enables, the PC advance/load strobes and the halted and
//                bus-error flags. Optional single-step mode is enabled by
//                defining PRCO_SINGLE_STEP_EN, which adds input i_step.
//  Revision    : 1.0  initial release
// ============================================================================
module prco_pipe_ctrl #(
  parameter int RAM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
`ifdef PRCO_SINGLE_STEP_EN
  input  logic             i_step,
`endif
  input  logic             i_fetch_valid,
  input  logic             i_dec_ce,
  input  logic             i_dec_fetch,
  input  logic             i_dec_reg_we,
  input  logic             i_dec_req_ram,
  input  logic             i_dec_req_ram_we,
  input  logic             i_dec_uart,
  input  logic             i_dec_halt,
  input  logic             i_jmp_taken,
  input  logic             i_ram_ack,
  input  logic             i_uart_busy,
  output logic             q_fetch_ce,
  output logic             q_dec_ce,
  output logic             q_alu_ce,
  output logic             q_mem_ce,
  output logic             q_mem_we,
  output logic             q_wb_ce,
  output logic             q_uart_we,
  output logic             q_pc_inc,
  output logic             q_pc_load,
  output logic             q_halted,
  output logic             q_bus_err,
  output logic [2:0]       q_state,
  output logic [CNT_W-1:0] q_retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // Counter only needs to reach RAM_TIMEOUT-1; +1 keeps width >= 1 for RAM_TIMEOUT=1.
  localparam int            TW       = $clog2(RAM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RAM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             first_q, first_d;      // first cycle spent in current state
  logic             reg_we_q, reg_we_d;
  logic             req_ram_q, req_ram_d;
  logic             req_ram_we_q, req_ram_we_d;
  logic             uart_q, uart_d;
  logic             jmp_q, jmp_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             retire_jmp;
`ifdef PRCO_SINGLE_STEP_EN
  logic             armed_q, armed_d;      // a step pulse was accepted in IDLE
`endif

  // State and latched-flag registers, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      first_q      <= 1'b1;
      reg_we_q     <= 1'b0;
      req_ram_q    <= 1'b0;
      req_ram_we_q <= 1'b0;
      uart_q       <= 1'b0;
      jmp_q        <= 1'b0;
      tmo_q        <= '0;
      bus_err_q    <= 1'b0;
      retired_q    <= '0;
`ifdef PRCO_SINGLE_STEP_EN
      armed_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      reg_we_q     <= reg_we_d;
      req_ram_q    <= req_ram_d;
      req_ram_we_q <= req_ram_we_d;
      uart_q       <= uart_d;
      jmp_q        <= jmp_d;
      tmo_q        <= tmo_d;
      bus_err_q    <= bus_err_d;
      retired_q    <= retired_d;
`ifdef PRCO_SINGLE_STEP_EN
      armed_q      <= armed_d;
`endif
    end
  end

  // Next-state and strobe decode; strobes are combinational so a reset
  // drops them immediately, mid-access included.
  always_comb begin
    state_d      = state_q;
    reg_we_d     = reg_we_q;
    req_ram_d    = req_ram_q;
    req_ram_we_d = req_ram_we_q;
    uart_d       = uart_q;
    jmp_d        = jmp_q;
    tmo_d        = '0;
    bus_err_d    = bus_err_q;
    retired_d    = retired_q;
    retire       = 1'b0;
    retire_jmp   = 1'b0;
`ifdef PRCO_SINGLE_STEP_EN
    armed_d      = armed_q;
`endif
    q_fetch_ce   = 1'b0;
    q_dec_ce     = 1'b0;
    q_alu_ce     = 1'b0;
    q_mem_ce     = 1'b0;
    q_mem_we     = 1'b0;
    q_wb_ce      = 1'b0;
    q_uart_we    = 1'b0;
    q_pc_inc     = 1'b0;
    q_pc_load    = 1'b0;
    q_halted     = 1'b0;

    case (state_q)
      S_IDLE: begin
`ifdef PRCO_SINGLE_STEP_EN
        if (i_en && i_step) begin
          armed_d = 1'b1;
          state_d = S_FETCH;
        end
`else
        if (i_en) state_d = S_FETCH;
`endif
      end
      S_FETCH: begin
        if (first_q) begin
`ifdef PRCO_SINGLE_STEP_EN
          if (!i_en || !armed_q) begin
            state_d = S_IDLE;
          end else begin
            q_fetch_ce = 1'b1;
            armed_d    = 1'b0;
          end
`else
          if (!i_en) state_d = S_IDLE;
          else       q_fetch_ce = 1'b1;
`endif
        end else if (i_fetch_valid) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (first_q) begin
          q_dec_ce = 1'b1;
        end else if (i_dec_halt) begin
          state_d = S_HALT;
        end else if (i_dec_fetch) begin
          retire = 1'b1;
        end else if (i_dec_ce) begin
          reg_we_d     = i_dec_reg_we;
          req_ram_d    = i_dec_req_ram;
          req_ram_we_d = i_dec_req_ram_we;
          uart_d       = i_dec_uart;
          jmp_d        = 1'b0;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        q_alu_ce = first_q;
        // Branch outcome may arrive in any EXEC cycle; keep it once seen.
        jmp_d    = jmp_q | i_jmp_taken;
        if (!(uart_q && i_uart_busy)) begin
          q_uart_we = uart_q;
          if (req_ram_q)     state_d = S_MEM;
          else if (reg_we_q) state_d = S_WB;
          else begin
            retire     = 1'b1;
            retire_jmp = jmp_q | i_jmp_taken;
          end
        end
      end
      S_MEM: begin
        q_mem_ce = 1'b1;
        q_mem_we = req_ram_we_q;
        if (i_ram_ack) begin
          if (reg_we_q) state_d = S_WB;
          else begin
            retire     = 1'b1;
            retire_jmp = jmp_q;
          end
        end else if (tmo_q == TMO_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WB: begin
        q_wb_ce    = 1'b1;
        retire     = 1'b1;
        retire_jmp = jmp_q;
      end
      S_HALT: begin
        q_halted = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    // Retire: exactly one PC strobe, count the instruction, refetch.
    if (retire) begin
      state_d   = S_FETCH;
      q_pc_load = retire_jmp;
      q_pc_inc  = !retire_jmp;
      retired_d = retired_q + 1'b1;
    end

    first_d = (state_d != state_q);
  end

  assign q_bus_err = bus_err_q;
  assign q_state   = state_q;
  assign q_retired = retired_q;

endmodule
`default_nettype wire
